// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel registered stream multiplexer.
// One channel per cycle is granted, chosen either by a fixed select or by
// round-robin arbitration. The granted beat is registered onto a single
// valid/ready output stream with one cycle of latency and full throughput.
module stream_mux_arb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch
);

  // Round-robin pointer: the channel that has first claim on the next grant.
  // It always stays below NCH.
  logic [SELW-1:0]  ptr;

  logic             free;
  logic             gnt_valid;
  logic [SELW-1:0]  gnt_idx;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;
  logic [SELW-1:0]  ptr_next;

  // Output register may load when empty or being drained this cycle.
  // Reset suppresses all handshakes so no source believes its beat was taken.
  assign free = (~out_valid | out_ready) & ~rst;

  // Grant selection: fixed select or rotating priority starting at ptr.
  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    if (!mode) begin
      // A select value at or above NCH matches no channel, so never grants.
      for (int unsigned i = 0; i < NCH; i++) begin
        if ((sel == SELW'(i)) && in_valid[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SELW'(i);
        end
      end
    end else begin
      // Scan ptr, ptr+1, ..., wrapping at NCH; the first valid channel wins.
      for (int unsigned k = 0; k < NCH; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NCH) begin
          idx = idx - NCH;
        end
        if (!gnt_valid && in_valid[idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SELW'(idx);
        end
      end
    end
  end

  // Per-channel ready and data selection for the granted channel.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_valid && (gnt_idx == SELW'(i))) begin
        in_ready[i] = free;
        gnt_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = gnt_valid & free;

  // Pointer advance target: one past the granted channel, wrapping at NCH.
  always_comb begin
    if (int'(gnt_idx) == NCH - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = gnt_idx + SELW'(1);
    end
  end

  // Output register and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        if (mode) begin
          ptr <= ptr_next;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
